// File: rtl/vpe_rf_writeback.sv
// vpe_rf_writeback: VPE writeback stage.
// Restores natural lane order, optionally applies ReLU, buffers vectors in a
// small FIFO and dispatches each head entry to the register file, the output
// stream, both, or nowhere. Upstream cannot stall, so a vector arriving while
// the FIFO is full is dropped and reported through the sticky o_ovf flag.
//
// Stream handshake: a beat transfers on a rising edge where o_st_v=1 and
// i_st_rdy=1. While o_st_v=1 and i_st_rdy=0, o_st_data and o_st_idx hold.
// A new beat may be loaded on the same edge that accepts the previous one.
module vpe_rf_writeback #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] i_data,
    input  logic        i_data_v,
    input  logic        i_en_relu,
    input  logic [4:0]  i_rf_idx,
    input  logic [1:0]  i_rf_mux,
    output logic        o_rf_we,
    output logic [4:0]  o_rf_waddr,
    output logic [63:0] o_rf_wdata,
    output logic [63:0] o_st_data,
    output logic [4:0]  o_st_idx,
    output logic        o_st_v,
    input  logic        i_st_rdy,
    output logic        o_full,
    output logic        o_empty,
    output logic        o_ovf,
    input  logic        i_clr_ovf
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

    logic [63:0]   data_mem [DEPTH];
    logic [4:0]    idx_mem  [DEPTH];
    logic [1:0]    mux_mem  [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;

    logic [63:0] in_xform;
    logic        push;
    logic        drop;
    logic        head_valid;
    logic [1:0]  head_mux;
    logic        route_rf;
    logic        route_st;
    logic        slot_free;
    logic        fire;

    // Ingress transform: reverse lane order, then zero negative lanes under ReLU.
    always_comb begin
        in_xform = '0;
        for (int k = 0; k < 8; k++) begin
            logic [7:0] lane;
            lane = i_data[63-8*k -: 8];
            if (i_en_relu && lane[7]) begin
                lane = 8'h00;
            end
            in_xform[8*k +: 8] = lane;
        end
    end

    // Push/drop decisions use the count at the start of the cycle only.
    assign push = i_data_v && (count != FULL_CNT);
    assign drop = i_data_v && (count == FULL_CNT);

    // Head routing: 00 RF, 01 stream, 10 RF+stream, 11 discard.
    assign head_valid = (count != '0);
    assign head_mux   = mux_mem[rd_ptr];
    assign route_rf   = !head_mux[0];
    assign route_st   = head_mux[0] ^ head_mux[1];
    assign slot_free  = !o_st_v || i_st_rdy;
    assign fire       = head_valid && (!route_st || slot_free);

    assign o_full  = (count == FULL_CNT);
    assign o_empty = (count == '0);

    // FIFO storage; contents need no reset because count gates their use.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr] <= in_xform;
            idx_mem[wr_ptr]  <= i_rf_idx;
            mux_mem[wr_ptr]  <= i_rf_mux;
        end
    end

    // Pointers and occupancy count; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (fire) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, fire})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow flag; a new drop outranks a clear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_ovf <= 1'b0;
        end else if (drop) begin
            o_ovf <= 1'b1;
        end else if (i_clr_ovf) begin
            o_ovf <= 1'b0;
        end
    end

    // RF write port: one-cycle strobe, address/data held between writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_rf_we    <= 1'b0;
            o_rf_waddr <= '0;
            o_rf_wdata <= '0;
        end else begin
            o_rf_we <= fire && route_rf;
            if (fire && route_rf) begin
                o_rf_waddr <= idx_mem[rd_ptr];
                o_rf_wdata <= data_mem[rd_ptr];
            end
        end
    end

    // Stream register: load on dispatch, otherwise retire when accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_st_v    <= 1'b0;
            o_st_data <= '0;
            o_st_idx  <= '0;
        end else if (fire && route_st) begin
            o_st_v    <= 1'b1;
            o_st_data <= data_mem[rd_ptr];
            o_st_idx  <= idx_mem[rd_ptr];
        end else if (i_st_rdy) begin
            o_st_v <= 1'b0;
        end
    end

endmodule

// File: doc/vpe_rf_writeback.md
# vpe_rf_writeback

Writeback stage for VPE 2.1, sitting directly downstream of the VPE bias adder. It consumes the bias-added int8x8 vector together with its sideband (`en_relu`, `rf_idx`, `rf_mux`). It restores natural lane order, applies ReLU, and buffers results in a small FIFO. It then dispatches each result to the vector register file, to a backpressured output stream, to both, or discards it. The upstream pipeline has no stall, so overflow is detected and flagged rather than back-propagated.

## Interface
- DEPTH, 4, FIFO entries; power of 2, minimum 2.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- i_data  in  64  bias-added vector; lane k occupies bits [63-8k:56-8k], so lane 0 is at the MSB.
- i_data_v  in  1  input valid, one vector per cycle.
- i_en_relu  in  1  apply ReLU to this vector.
- i_rf_idx  in  5  destination RF entry.
- i_rf_mux  in  2  routing: 00 RF only, 01 stream only, 10 RF+stream, 11 discard.
- o_rf_we  out  1  RF write strobe, single cycle.
- o_rf_waddr  out  5  RF write address.
- o_rf_wdata  out  64  RF write data; lane k at [8k+7:8k].
- o_st_data  out  64  stream data, same lane order as o_rf_wdata.
- o_st_idx  out  5  rf_idx tag accompanying the stream beat.
- o_st_v  out  1  stream valid.
- i_st_rdy  in  1  stream ready.
- o_full  out  1  FIFO count == DEPTH.
- o_empty  out  1  FIFO count == 0.
- o_ovf  out  1  sticky flag: a vector was dropped.
- i_clr_ovf  in  1  clears o_ovf.

## Operation
- **Ingress transform** (combinational, applied before the FIFO write):
  - Lane reorder: out[8k+7:8k] = i_data[63-8k:56-8k].
  - ReLU when i_en_relu=1: any lane with bit7=1 becomes 0x00. Otherwise data passes unchanged.
- **FIFO**:
  - Each entry stores {data64, idx5, mux2}.
  - Read and write pointers wrap modulo DEPTH; count ranges 0..DEPTH.
- **Push**:
  - Accepted iff i_data_v=1 and count<DEPTH. The check uses count at the start of the cycle, so a pop in the same cycle does not admit a push when full.
  - i_data_v=1 while full: the vector is dropped and o_ovf is set.
  - If set and i_clr_ovf occur in the same cycle, set wins.
- **Dispatch** (head entry, at most one per cycle):
  - Stream slot free = !o_st_v || i_st_rdy.
  - mux 00 or 11: always fires.
  - mux 01 or 10: fires only when the stream slot is free.
  - Fire pops the head entry.
  - mux 00 or 10: registers o_rf_we=1, o_rf_waddr=idx, o_rf_wdata=data.
  - mux 01 or 10: loads o_st_data/o_st_idx and sets o_st_v=1.
  - mux 11: no output activity.
- **Stream handshake**:
  - o_st_v, o_st_data and o_st_idx stay stable until i_st_rdy=1.
  - o_st_v falls after the accepting edge unless a new dispatch reloads it in the same cycle, which allows back-to-back beats.
- **Ordering**: strict FIFO order. A stream-blocked head also blocks subsequent RF-only entries (no bypass).
- **Reset** (asynchronous, also mid-operation):
  - Pointers and count go to 0; buffered entries and any pending stream beat are lost.
  - Outputs: o_rf_we=0, o_rf_waddr=0, o_rf_wdata=0, o_st_v=0, o_st_data=0, o_st_idx=0, o_full=0, o_empty=1, o_ovf=0.

## Timing
- o_rf_we is a single-cycle pulse per dispatched RF entry; it is 0 in all other cycles.
- Latency with an empty FIFO and free stream slot:
  - Vector presented in cycle N is written to the FIFO at edge N.
  - It dispatches at edge N+1.
  - o_rf_we and/or o_st_v are high during cycle N+2.
- Throughput: 1 vector/cycle sustained when i_st_rdy=1 or with RF-only traffic.
- o_full and o_empty are registered-count decodes: they update on the edge that changes count.
- A simultaneous push and pop with count<DEPTH leaves count unchanged.

## Test plan
- **Lane reorder**
  - Stimulus: i_data=0x0102030405060708, relu=0, mux=00, idx=5, presented in cycle 0.
  - Required: in cycle 2, o_rf_we=1, waddr=5, wdata=0x0807060504030201; o_st_v stays 0.
- **ReLU**
  - Stimulus: i_data=0x817F00FF8001C040, relu=1, mux=00.
  - Required: wdata=0x4000010000007F00.
  - Same vector with relu=0: wdata=0x40C00180FF007F81.
- **Backpressure and overflow**
  - Stimulus: i_st_rdy=0, mux=01, vectors A..F on 6 consecutive cycles.
  - Required: A is held on o_st_v and B..E fill the FIFO (o_full=1). F is dropped and o_ovf=1.
  - Then i_st_rdy=1: A,B,C,D,E emerge on 5 consecutive cycles, then o_empty=1.
  - i_clr_ovf then clears o_ovf.
- **Dual route and discard**
  - Stimulus: mux=10, idx=9 → o_rf_we pulse and o_st_v in the same cycle, identical data, o_st_idx=9.
  - Stimulus: mux=11 → no o_rf_we and no o_st_v; FIFO returns to empty.
- **Head-of-line blocking**
  - Stimulus: mux=01 entry with i_st_rdy=0 (stream slot already occupied), followed by a mux=00 entry.
  - Required: no o_rf_we until i_st_rdy=1.
- **Reset mid-operation**
  - Stimulus: 3 entries buffered and o_st_v=1, then rst_n pulsed low.
  - Required: all outputs take their reset values immediately. After release, a new vector appears 2 cycles after input with no stale data.
